// File: rtl/jogo_sequencia_n.sv
// LED-sequence memory game round engine: stores a pattern sequence, replays it,
// then checks timed button plays and ends each round with an all-LED blink.
module jogo_sequencia_n #(
  parameter int NB       = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int TW       = 9,
  parameter int TIMEOUT  = 300,
  parameter int TICK_DIV = 1000,
  parameter int BLINK    = 500,
  parameter int NBLINK   = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          escreve,
  input  logic [AW-1:0] endereco,
  input  logic [NB-1:0] dado,
  input  logic [AW-1:0] ultimo,
  input  logic          iniciar,
  input  logic [NB-1:0] botoes,
  output logic [NB-1:0] leds,
  output logic          pronto,
  output logic          acertou,
  output logic          errou,
  output logic          timeout,
  output logic [TW-1:0] tempo_restante,
  output logic [2:0]    db_estado,
  output logic [AW-1:0] db_indice
);

  localparam int CW = $clog2(BLINK + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int KW = $clog2(NBLINK + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOSTRA_ON  = 3'd1,
    MOSTRA_OFF = 3'd2,
    ESPERA     = 3'd3,
    COMPARA    = 3'd4,
    FIM        = 3'd5
  } estado_t;

  estado_t       r_estado;
  logic [NB-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_indice;
  logic [AW-1:0] r_ultimo;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_presc;
  logic [KW-1:0] r_nblink;
  logic          r_fim_on;
  logic [NB-1:0] r_jogada;
  logic          r_bot_ant;

  logic          w_bot_or;
  logic          w_jogada;
  logic          w_escrita_ok;
  logic          w_fim_passo;
  logic          w_cnt_fim;
  logic [AW-1:0] w_indice_prox;
  logic [NB-1:0] w_mem_atual;
  logic [NB-1:0] w_mem_prox;

  assign w_bot_or      = |botoes;
  assign w_jogada      = w_bot_or & ~r_bot_ant;
  assign w_escrita_ok  = escreve & ((r_estado == IDLE) | (r_estado == FIM));
  assign w_fim_passo   = (r_indice == r_ultimo);
  assign w_cnt_fim     = (r_cnt == CW'(BLINK - 1));
  assign w_indice_prox = r_indice + 1'b1;
  assign w_mem_atual   = r_mem[r_indice];
  assign w_mem_prox    = r_mem[w_indice_prox];

  assign db_estado = r_estado;
  assign db_indice = r_indice;

  // Sequence memory has no reset so the stored game survives a round abort.
  always_ff @(posedge clock) begin
    if (w_escrita_ok) r_mem[endereco] <= dado;
  end

  // Edge detector runs in every state so held buttons never count as a new play.
  always_ff @(posedge clock) begin
    r_bot_ant <= w_bot_or;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado       <= IDLE;
      leds           <= '0;
      pronto         <= 1'b0;
      acertou        <= 1'b0;
      errou          <= 1'b0;
      timeout        <= 1'b0;
      tempo_restante <= '0;
      r_indice       <= '0;
      r_ultimo       <= '0;
      r_cnt          <= '0;
      r_presc        <= '0;
      r_nblink       <= '0;
      r_fim_on       <= 1'b0;
      r_jogada       <= '0;
    end else begin
      unique case (r_estado)
        IDLE, FIM: begin
          if (iniciar) begin
            r_estado <= MOSTRA_ON;
            acertou  <= 1'b0;
            errou    <= 1'b0;
            timeout  <= 1'b0;
            r_indice <= '0;
            r_cnt    <= '0;
            r_ultimo <= ultimo;
            r_jogada <= '0;
            leds     <= r_mem[0];
          end else if (r_estado == FIM && r_nblink != KW'(NBLINK)) begin
            // Each flash is an on phase then an off phase; count completes after the off phase.
            if (w_cnt_fim) begin
              r_cnt <= '0;
              if (r_fim_on) begin
                leds     <= '0;
                r_fim_on <= 1'b0;
              end else begin
                r_nblink <= r_nblink + 1'b1;
                if (r_nblink != KW'(NBLINK - 1)) begin
                  leds     <= '1;
                  r_fim_on <= 1'b1;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        MOSTRA_ON: begin
          if (w_cnt_fim) begin
            r_cnt    <= '0;
            leds     <= '0;
            r_estado <= MOSTRA_OFF;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        MOSTRA_OFF: begin
          if (w_cnt_fim) begin
            r_cnt <= '0;
            if (w_fim_passo) begin
              r_estado       <= ESPERA;
              r_indice       <= '0;
              pronto         <= 1'b1;
              tempo_restante <= TW'(TIMEOUT);
              r_presc        <= '0;
              leds           <= r_jogada;
            end else begin
              r_estado <= MOSTRA_ON;
              r_indice <= w_indice_prox;
              leds     <= w_mem_prox;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ESPERA: begin
          if (w_jogada) begin
            r_jogada <= botoes;
            leds     <= botoes;
            pronto   <= 1'b0;
            r_estado <= COMPARA;
          end else if (tempo_restante == '0) begin
            timeout  <= 1'b1;
            pronto   <= 1'b0;
            r_estado <= FIM;
            leds     <= '1;
            r_fim_on <= 1'b1;
            r_nblink <= '0;
            r_cnt    <= '0;
          end else if (r_presc == PW'(TICK_DIV - 1)) begin
            r_presc        <= '0;
            tempo_restante <= tempo_restante - 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        COMPARA: begin
          if (r_jogada != w_mem_atual || w_fim_passo) begin
            errou    <= (r_jogada != w_mem_atual);
            acertou  <= (r_jogada == w_mem_atual);
            r_estado <= FIM;
            leds     <= '1;
            r_fim_on <= 1'b1;
            r_nblink <= '0;
            r_cnt    <= '0;
          end else begin
            r_indice       <= w_indice_prox;
            r_estado       <= ESPERA;
            pronto         <= 1'b1;
            tempo_restante <= TW'(TIMEOUT);
            r_presc        <= '0;
          end
        end

        default: r_estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jogo_sequencia_n.sv
// Scoreboard bench for jogo_sequencia_n: a round-level model queues expected
// observations, and a negedge monitor pops and compares them.
module tb_jogo_sequencia_n;
  localparam int NB = 4, DEPTH = 4, AW = 2, TW = 3;
  localparam int TIMEOUT = 5, TICK_DIV = 4, BLINK = 2, NBLINK = 2;
  localparam int LIMIT = TIMEOUT * TICK_DIV;   // last wait cycle on which a play is taken
  localparam int FIMLEN = 2 * BLINK * NBLINK;

  logic          clock, reset, escreve, iniciar;
  logic [AW-1:0] endereco, ultimo;
  logic [NB-1:0] dado, botoes, leds;
  logic          pronto, acertou, errou, timeout;
  logic [TW-1:0] tempo_restante;
  logic [2:0]    db_estado;
  logic [AW-1:0] db_indice;

  jogo_sequencia_n #(
    .NB(NB), .DEPTH(DEPTH), .AW(AW), .TW(TW), .TIMEOUT(TIMEOUT),
    .TICK_DIV(TICK_DIV), .BLINK(BLINK), .NBLINK(NBLINK)
  ) dut (
    .clock(clock), .reset(reset), .escreve(escreve), .endereco(endereco),
    .dado(dado), .ultimo(ultimo), .iniciar(iniciar), .botoes(botoes),
    .leds(leds), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .tempo_restante(tempo_restante),
    .db_estado(db_estado), .db_indice(db_indice)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind: 0 = replay LED cycle, 1 = entry into a wait, 2 = round result
  typedef struct {
    int            kind;
    logic [NB-1:0] led;
    int            idx;
    logic [2:0]    flags;
    int            tempo;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] m_mem [DEPTH];
  logic [NB-1:0] pl_p [DEPTH];
  int            pl_d [DEPTH];
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic pop(input int kind, output exp_t e);
    if (q.size() == 0) begin
      chk("scoreboard_underflow", 0, 1);
      e.kind = -1; e.led = '0; e.idx = 0; e.flags = '0; e.tempo = 0;
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
    end
  endtask

  function automatic exp_t mk(int kind, logic [NB-1:0] led, int idx, logic [2:0] flags, int tempo);
    exp_t e;
    e.kind = kind; e.led = led; e.idx = idx; e.flags = flags; e.tempo = tempo;
    return e;
  endfunction

  // Monitor
  int   m_prev = 0;
  int   k_esp = 0;
  int   k_fim = 0;
  exp_t m_fim;
  always @(negedge clock) begin
    int   st;
    exp_t e;
    st = int'(db_estado);
    if (mon_en) begin
      if (st == 1 || st == 2) begin
        pop(0, e);
        chk("replay_leds", int'(leds), int'(e.led));
      end
      if (st == 3) begin
        if (m_prev != 3) begin
          pop(1, e);
          chk("wait_index", int'(db_indice), e.idx);
          chk("wait_leds", int'(leds), int'(e.led));
          chk("wait_pronto", int'(pronto), 1);
          k_esp = 0;
        end
        chk("tempo_restante", int'(tempo_restante), TIMEOUT - k_esp / TICK_DIV);
        k_esp++;
      end
      if (st == 4) chk("compare_pronto", int'(pronto), 0);
      if (st == 5) begin
        if (m_prev != 5) begin
          pop(2, m_fim);
          chk("end_tempo", int'(tempo_restante), m_fim.tempo);
          chk("end_pronto", int'(pronto), 0);
          k_fim = 0;
        end
        chk("result_flags", int'({acertou, errou, timeout}), int'(m_fim.flags));
        if (k_fim < FIMLEN + 3)
          chk("end_blink", int'(leds),
              (k_fim < FIMLEN && ((k_fim / BLINK) % 2) == 0) ? (1 << NB) - 1 : 0);
        k_fim++;
      end
    end
    m_prev = st;
  end

  // Round-level reference: what the player sees, derived from the game rules.
  task automatic plan_round(input int ult, output int nsteps);
    logic [NB-1:0] prev;
    for (int i = 0; i <= ult; i++) begin
      for (int c = 0; c < BLINK; c++) q.push_back(mk(0, m_mem[i], 0, 3'b000, 0));
      for (int c = 0; c < BLINK; c++) q.push_back(mk(0, '0, 0, 3'b000, 0));
    end
    prev = '0;
    nsteps = ult + 1;
    for (int i = 0; i <= ult; i++) begin
      q.push_back(mk(1, prev, i, 3'b000, 0));
      if (pl_d[i] > LIMIT) begin
        q.push_back(mk(2, '0, 0, 3'b001, 0));
        nsteps = i + 1;
        return;
      end
      if (pl_p[i] != m_mem[i]) begin
        q.push_back(mk(2, '0, 0, 3'b010, TIMEOUT - pl_d[i] / TICK_DIV));
        nsteps = i + 1;
        return;
      end
      if (i == ult) begin
        q.push_back(mk(2, '0, 0, 3'b100, TIMEOUT - pl_d[i] / TICK_DIV));
        return;
      end
      prev = pl_p[i];
    end
  endtask

  task automatic gen_plays();
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      logic [NB-1:0] p;
      r = int'($urandom_range(0, 9));
      pl_d[i] = int'($urandom_range(0, 6));
      pl_p[i] = m_mem[i];
      if (r == 6) pl_d[i] = LIMIT;
      else if (r == 9) pl_d[i] = LIMIT + 1;
      else if (r == 7 || r == 8) begin
        p = (r == 8) ? (m_mem[i] | NB'(1 << $urandom_range(0, NB - 1))) : NB'($urandom_range(1, 15));
        while (p == m_mem[i] || p == '0) p = NB'($urandom_range(1, 15));
        pl_p[i] = p;
      end
    end
  endtask

  task automatic all_correct(input int d);
    for (int i = 0; i < DEPTH; i++) begin
      pl_p[i] = m_mem[i];
      pl_d[i] = d;
    end
  endtask

  task automatic write_mem(input int addr, input logic [NB-1:0] v);
    @(negedge clock);
    escreve = 1'b1; endereco = AW'(addr); dado = v;
    @(negedge clock);
    escreve = 1'b0;
    m_mem[addr] = v;
  endtask

  task automatic wait_pronto(output bit ok);
    int n = 0;
    while (!(pronto && db_estado == 3'd3) && n < 300) begin
      @(negedge clock);
      n++;
    end
    ok = (n < 300);
    if (!ok) chk("wait_pronto_timeout", 0, 1);
  endtask

  task automatic drive_plays(input int nsteps);
    bit ok;
    int n;
    for (int i = 0; i < nsteps; i++) begin
      wait_pronto(ok);
      if (!ok) return;
      if (pl_d[i] <= LIMIT) begin
        repeat (pl_d[i]) @(negedge clock);
        botoes = pl_p[i];
        @(negedge clock);
        botoes = '0;
      end
    end
    n = 0;
    while (db_estado != 3'd5 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("wait_end_timeout", 0, 1);
    repeat (FIMLEN + 4) @(negedge clock);
  endtask

  // Starts a round; a write aimed at address 1 during the replay must be ignored.
  task automatic start_round(input int ult);
    @(negedge clock);
    ultimo = AW'(ult); iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0; ultimo = AW'($urandom_range(0, DEPTH - 1));
    escreve = 1'b1; endereco = AW'(1); dado = NB'($urandom_range(0, 15));
    @(negedge clock);
    escreve = 1'b0;
  endtask

  task automatic run_round(input int ult);
    int ns;
    plan_round(ult, ns);
    start_round(ult);
    drive_plays(ns);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    bit ok;
    reset = 1'b0; escreve = 1'b0; iniciar = 1'b0; botoes = '0;
    endereco = '0; dado = '0; ultimo = '0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", int'({leds, pronto, acertou, errou, timeout, tempo_restante, db_estado, db_indice}), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    write_mem(0, 4'b0001); write_mem(1, 4'b0010);
    write_mem(2, 4'b0100); write_mem(3, 4'b1000);

    // Reset held with buttons and iniciar asserted, then release straight into a round.
    @(negedge clock);
    reset = 1'b0; botoes = '1; iniciar = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("reset_hold_outputs", int'({leds, pronto, acertou, errou, timeout, tempo_restante, db_estado, db_indice}), 0);
    end
    all_correct(1);
    plan_round(3, ns);
    ultimo = AW'(3);
    reset = 1'b1;
    @(negedge clock);
    chk("start_after_reset", int'(db_estado), 1);
    iniciar = 1'b0; botoes = '0;
    drive_plays(ns);

    // Two-button press on the first step is a miss.
    all_correct(0);
    pl_p[0] = 4'b0011;
    run_round(3);

    // Expiry with no play, then a play exactly on the expiry cycle.
    all_correct(0);
    pl_d[0] = LIMIT + 1;
    run_round(3);
    all_correct(0);
    pl_d[0] = LIMIT; pl_d[1] = LIMIT + 1;
    run_round(3);

    // Abort in the middle of a wait; memory must survive.
    all_correct(0);
    plan_round(3, ns);
    start_round(3);
    wait_pronto(ok);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("abort_outputs", int'({leds, pronto, acertou, errou, timeout, tempo_restante, db_estado, db_indice}), 0);
    q.delete();
    reset = 1'b1;
    all_correct(2);
    run_round(3);

    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        write_mem(int'($urandom_range(0, DEPTH - 1)), NB'($urandom_range(1, 15)));
      gen_plays();
      run_round(int'($urandom_range(0, DEPTH - 1)));
    end

    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jogo_sequencia_n.md
Name: jogo_sequencia_n

Overview:
- Parametrised round engine for the LED-sequence memory game.
- Stores a programmable sequence of NB-bit one-hot LED patterns and replays it on the LEDs with timed on/off phases.
- Collects the player's button presses, checks each one against the stored pattern under a per-play timeout, and reports hit, miss or timeout with an end-of-round blink.
- Replaces fixed 4-button, fixed-ROM datapath plus external control with one self-contained block; sits between board I/O and the top-level mode/display logic.

Parameters:
NB, 4, number of buttons/LEDs (channels)
DEPTH, 16, maximum sequence length
AW, 4, address width, clog2(DEPTH)
TW, 9, width of timeout counter
TIMEOUT, 300, ticks allowed per play
TICK_DIV, 1000, clock cycles per timeout tick
BLINK, 500, clock cycles per LED on phase and per LED off phase
NBLINK, 3, all-LED flashes at end of round

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
escreve  in  1  write enable for sequence memory
endereco  in  AW  write address
dado  in  NB  pattern to store
ultimo  in  AW  index of last step (length = ultimo+1)
iniciar  in  1  start/restart round (level, sampled per cycle)
botoes  in  NB  raw button levels (already synchronised)
leds  out  NB  LED drive
pronto  out  1  high while waiting for a play
acertou  out  1  round completed correctly
errou  out  1  wrong play
timeout  out  1  play not made in time
tempo_restante  out  TW  ticks left for current play
db_estado  out  3  FSM state encoding
db_indice  out  AW  current step index

Behaviour:
- reset=0 at a rising edge: state IDLE; leds, pronto, acertou, errou, timeout, tempo_restante, db_indice = 0; db_estado = 0. Memory contents are not cleared and persist across reset. Reset mid-round aborts immediately.
- States and encodings: IDLE=0, MOSTRA_ON=1, MOSTRA_OFF=2, ESPERA=3, COMPARA=4, FIM=5.
- escreve: honoured only in IDLE and FIM; ignored in all other states. Written data is visible from the next cycle.
- IDLE/FIM to MOSTRA_ON:
  - Triggered by iniciar=1; transition happens on the next edge.
  - Clears the result flags, index=0, cycle counter=0.
  - iniciar is ignored in every other state.
- MOSTRA_ON:
  - leds = mem[index] for exactly BLINK cycles, then MOSTRA_OFF.
- MOSTRA_OFF:
  - leds = 0 for BLINK cycles.
  - If index==ultimo: go to ESPERA with index=0; otherwise index+1 and back to MOSTRA_ON.
- ESPERA:
  - pronto=1; leds = registered play (0 until the first press).
  - On entry: tempo_restante=TIMEOUT, prescaler=0.
  - Prescaler counts 0..TICK_DIV-1; at wrap, tempo_restante decrements.
  - Play = rising edge of OR(botoes), using the internal edge detector. On a play, botoes is registered and the next state is COMPARA.
  - tempo_restante reaching 0 with no play: go to FIM with timeout=1.
  - Play and expiry on the same cycle: the play wins.
- COMPARA (one cycle, pronto=0):
  - Hit requires an exact match: registered play == mem[index]. Multiple buttons pressed = miss.
  - Miss: go to FIM with errou=1.
  - Hit with index==ultimo: go to FIM with acertou=1.
  - Hit otherwise: index+1, go back to ESPERA (timer reloads).
- FIM:
  - leds = all-ones for BLINK cycles, then 0 for BLINK cycles, repeated NBLINK times; leds then hold 0.
  - Result flags hold until iniciar or reset.
  - tempo_restante freezes at its last value.
- Buttons held across a state change do not create a new play; a release followed by a press is required.
- ultimo is sampled on leaving IDLE/FIM and held for the rest of the round.

Test Plan (NB=4, DEPTH=4, AW=2, TW=3, TIMEOUT=5, TICK_DIV=4, BLINK=2, NBLINK=2):
1. Hold reset=0 for 3 cycles with botoes=1111 and iniciar=1 -> all outputs 0, db_estado=0. Release reset -> MOSTRA_ON next edge.
2. Write 0001, 0010, 0100, 1000 to addresses 0-3, ultimo=3, pulse iniciar -> leds sequence 0001,0001,0000,0000,0010,… (16 cycles total), then pronto=1 and tempo_restante=5.
3. Play matching buttons for all 4 steps, each press 1 cycle with a release in between -> acertou=1, errou=0. leds then show 1111 x2, 0000 x2, 1111 x2, 0000 and stay 0.
4. Press 0011 at step 0 -> errou=1 two cycles after the press edge, acertou=0, timeout=0.
5. No press in ESPERA -> tempo_restante steps 5,4,3,2,1,0 every 4 cycles; timeout=1 and db_estado=5 one edge after reaching 0. A press landing on the expiry cycle goes to COMPARA instead.
6. escreve during MOSTRA_ON to address 1 -> memory unchanged (step 1 still shows 0010). Reset asserted during ESPERA -> IDLE, and memory still replays 0001 afterwards.
